sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single sram_core user interface between two requester ports (port 0, port 1), e.g. host and BIST/scrub engine.
- Round-robin arbitration per request; owns sram_core enable/read_not_write/addr/data_in; waits for core ready; returns completion (and read data) to the granted port only.
- Watchdog aborts an operation if core ready never arrives.

Parameters:
ADDR_W, 10, address width (6 row + 4 column bits)
DATA_W, 4, word width
TIMEOUT, 8, max BUSY cycles without mem_ready before abort (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held with command until p0_gnt
p0_we  in  1  port 0: 1=write, 0=read
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 command accepted this cycle (combinational)
p0_done  out  1  port 0 completion pulse
p0_rdata  out  DATA_W  port 0 read data, valid with p0_done on reads
p0_err  out  1  port 0 timeout flag, valid with p0_done
p1_*  (same seven signals for port 1)
mem_enable  out  1  to sram_core enable
mem_read_not_write  out  1  to sram_core read_not_write
mem_addr  out  ADDR_W  to sram_core addr
mem_data_in  out  DATA_W  to sram_core data_in
mem_data_out  in  DATA_W  from sram_core data_out
mem_ready  in  1  from sram_core ready
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; cmd registers 0; wait_cnt=0; last_gnt=1 (port 0 wins first tie).
- States: IDLE, BUSY, DONE.
- IDLE: no req -> stay. Exactly one reqX -> gntX=1 that cycle. Both -> grant port != last_gnt. On the edge with gnt: latch we/addr/wdata and granted id, last_gnt<=id, wait_cnt<=0, go BUSY. At most one gnt ever high; gnt never high outside IDLE.
- BUSY: mem_enable=1; mem_read_not_write=~we_q, mem_addr=addr_q, mem_data_in=wdata_q, all stable for the whole state. mem_ready=1 sampled -> capture mem_data_out (reads only), err_q=0, go DONE. Else if wait_cnt==TIMEOUT-1 -> err_q=1, rdata_q=0, go DONE. Else wait_cnt++.
- DONE (one cycle): mem_enable=0; pX_done=1 for granted port only; pX_rdata=captured data (0 for writes); pX_err=err_q. Next state IDLE unconditionally.
- Other port's done/rdata/err stay 0. rdata/err are 0 whenever done=0.
- mem_addr/mem_data_in/mem_read_not_write hold last latched values outside BUSY (0 after reset).
- mem_ready ignored outside BUSY.
- Latency: gnt at T; BUSY from T+1; if ready seen in cycle T+k, done at T+k+1; next gnt earliest T+k+2. Min grant-to-grant = 3 cycles.
- Port req held during BUSY/DONE is not accepted until IDLE; arbitration evaluated fresh in IDLE.
- Reset asserted mid-BUSY: mem_enable drops immediately, no done pulse; in-flight op lost.
- wait_cnt width = clog2(TIMEOUT); no wrap since abort at TIMEOUT-1.

Decomposition:
- Package sram_arb_pkg: state encoding (IDLE/BUSY/DONE), port id constants PORT0/PORT1, default TIMEOUT.
- Sub-module rr_arb2: 2-input round-robin grant logic (req[1:0], last_gnt -> gnt[1:0]); registers stay in top.

Test Plan:
- Port0 write addr 0x3A5 data 0xC; core ready 2 cycles after BUSY entry -> p0_gnt at T, mem_enable T+1..T+2, p0_done at T+3, p0_err=0, p0_rdata=0.
- Port1 read addr 0x010, core returns 0x9 with ready -> p1_done pulse with p1_rdata=0x9; p0_* all 0.
- Both req from reset, continuously -> grants alternate 0,1,0,1; each op completes before next gnt; no cycle with two gnts.
- Ready tied 0, TIMEOUT=8 -> mem_enable high exactly 8 cycles, then done with err=1, rdata=0; next request serviced normally.
- Change p0_addr while p0_req waiting behind port1 op -> value at gnt cycle latched; mem_addr constant throughout BUSY.
- rst_n low in 2nd BUSY cycle -> mem_enable, busy 0 immediately; no done; after release port 0 wins tie.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, port ids and defaults for the SRAM port arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam int DEF_TIMEOUT = 8;
endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; on a tie the port not granted last wins
import sram_arb_pkg::*;
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic [1:0] o_gnt
);
  assign o_gnt[0] = i_req[0] & (~i_req[1] | (i_last_gnt == PORT1));
  assign o_gnt[1] = i_req[1] & (~i_req[0] | (i_last_gnt == PORT0));
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram_core user interface between two requesters,
// round-robin per request, with a watchdog that aborts ops lacking mem_ready.
import sram_arb_pkg::*;
module sram_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_enable,
  output logic              mem_read_not_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT);
  state_t            r_state, w_next;
  logic              r_id, r_last_gnt, r_rnw, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [CW-1:0]     r_wait;
  logic [1:0]        w_arb, w_gnt;
  logic              w_timeout, w_done;

  rr_arb2 u_arb (.i_req({p1_req, p0_req}), .i_last_gnt(r_last_gnt), .o_gnt(w_arb));

  always_comb begin
    w_gnt     = (r_state == S_IDLE) ? w_arb : 2'b00;
    w_timeout = r_wait == CW'(TIMEOUT - 1);
    w_next    = (r_state == S_IDLE) ? ((|w_gnt) ? S_BUSY : S_IDLE) :
                (r_state == S_BUSY) ? ((mem_ready | w_timeout) ? S_DONE : S_BUSY) : S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id       <= PORT0;
      r_last_gnt <= PORT1;
      r_rnw      <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wait     <= '0;
    end else if (|w_gnt) begin
      r_id       <= w_gnt[1];
      r_last_gnt <= w_gnt[1];
      r_rnw      <= w_gnt[1] ? ~p1_we : ~p0_we;
      r_addr     <= w_gnt[1] ? p1_addr : p0_addr;
      r_wdata    <= w_gnt[1] ? p1_wdata : p0_wdata;
      r_wait     <= '0;
    end else if (r_state == S_BUSY) begin
      if (mem_ready) begin
        r_rdata <= r_rnw ? mem_data_out : '0;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else begin
        r_wait  <= r_wait + 1'b1;
      end
    end
  end

  // Command outputs hold the last latched values; only enable is gated by state.
  assign mem_enable         = r_state == S_BUSY;
  assign mem_read_not_write = r_rnw;
  assign mem_addr           = r_addr;
  assign mem_data_in        = r_wdata;
  assign busy               = r_state != S_IDLE;
  assign w_done             = r_state == S_DONE;
  assign p0_gnt             = w_gnt[0];
  assign p1_gnt             = w_gnt[1];
  assign p0_done            = w_done & (r_id == PORT0);
  assign p1_done            = w_done & (r_id == PORT1);
  assign p0_rdata           = p0_done ? r_rdata : '0;
  assign p1_rdata           = p1_done ? r_rdata : '0;
  assign p0_err             = p0_done & r_err;
  assign p1_err             = p1_done & r_err;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vectors with hand-computed expectations for sram_port_arbiter
module tb_sram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [9:0] p0_addr, p1_addr, mem_addr;
  logic [3:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_data_in, mem_data_out;
  logic       p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic       mem_enable, mem_read_not_write, mem_ready, busy;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(10), .DATA_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_enable(mem_enable), .mem_read_not_write(mem_read_not_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    rst_n = 1'b0; p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; mem_ready = 0; mem_data_out = 0;
    #3;
    chk("rst_enable", mem_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rnw", mem_read_not_write, 0);
    chk("rst_addr", mem_addr, 0);
    cyc; cyc;
    rst_n = 1'b1;
    // port 0 write, ready on second BUSY cycle
    p0_req = 1; p0_we = 1; p0_addr = 10'h3A5; p0_wdata = 4'hC;
    #1;
    chk("t1_gnt0", p0_gnt, 1);
    chk("t1_gnt1", p1_gnt, 0);
    cyc; p0_req = 0; #1;
    chk("t1_en1", mem_enable, 1);
    chk("t1_rnw", mem_read_not_write, 0);
    chk("t1_addr", mem_addr, 10'h3A5);
    chk("t1_din", mem_data_in, 4'hC);
    chk("t1_gnt_busy", p0_gnt, 0);
    cyc; mem_ready = 1; #1;
    chk("t1_en2", mem_enable, 1);
    cyc; mem_ready = 0; #1;
    chk("t1_done", p0_done, 1);
    chk("t1_err", p0_err, 0);
    chk("t1_rdata", p0_rdata, 0);
    chk("t1_en_done", mem_enable, 0);
    chk("t1_p1done", p1_done, 0);
    cyc;
    chk("t1_idle", busy, 0);
    chk("t1_hold_addr", mem_addr, 10'h3A5);
    // port 1 read returning 0x9
    p1_req = 1; p1_we = 0; p1_addr = 10'h010;
    #1;
    chk("t2_gnt1", p1_gnt, 1);
    cyc; p1_req = 0; mem_ready = 1; mem_data_out = 4'h9; #1;
    chk("t2_rnw", mem_read_not_write, 1);
    chk("t2_addr", mem_addr, 10'h010);
    cyc; mem_ready = 0; mem_data_out = 0; #1;
    chk("t2_done", p1_done, 1);
    chk("t2_rdata", p1_rdata, 4'h9);
    chk("t2_p0done", p0_done, 0);
    chk("t2_p0rdata", p0_rdata, 0);
    chk("t2_p0err", p0_err, 0);
    cyc;
    // both ports request continuously: 0,1,0,1
    p0_req = 1; p0_we = 0; p0_addr = 10'h100;
    p1_req = 1; p1_we = 0; p1_addr = 10'h200;
    for (int i = 0; i < 4; i++) begin
      e = i % 2;
      #1;
      chk($sformatf("t3_gnt0_%0d", i), p0_gnt, e == 0);
      chk($sformatf("t3_gnt1_%0d", i), p1_gnt, e == 1);
      cyc; mem_ready = 1; mem_data_out = 4'(i + 1); #1;
      chk($sformatf("t3_addr_%0d", i), mem_addr, e ? 10'h200 : 10'h100);
      chk($sformatf("t3_nognt_b_%0d", i), {p1_gnt, p0_gnt}, 0);
      cyc; mem_ready = 0; mem_data_out = 0; #1;
      chk($sformatf("t3_nognt_d_%0d", i), {p1_gnt, p0_gnt}, 0);
      chk($sformatf("t3_done_%0d", i), {p1_done, p0_done}, e ? 2'b10 : 2'b01);
      chk($sformatf("t3_rdata_%0d", i), e ? p1_rdata : p0_rdata, i + 1);
      cyc;
    end
    p0_req = 0; p1_req = 0;
    // watchdog: ready never arrives on a port 0 read
    cyc;
    p0_req = 1; p0_we = 0; p0_addr = 10'h0F0; mem_data_out = 4'hF;
    #1;
    chk("t4_gnt0", p0_gnt, 1);
    cyc; p0_req = 0; #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_en_%0d", i), mem_enable, 1);
      cyc;
    end
    chk("t4_en_off", mem_enable, 0);
    chk("t4_done", p0_done, 1);
    chk("t4_err", p0_err, 1);
    chk("t4_rdata", p0_rdata, 0);
    cyc; mem_data_out = 0;
    p1_req = 1; p1_we = 1; p1_addr = 10'h001; p1_wdata = 4'h3;
    #1;
    chk("t4_next_gnt", p1_gnt, 1);
    cyc; p1_req = 0; mem_ready = 1; #1;
    cyc; mem_ready = 0; #1;
    chk("t4_next_done", p1_done, 1);
    chk("t4_next_err", p1_err, 0);
    cyc;
    // port 0 address changes while waiting; value at grant is latched
    p1_req = 1; p1_we = 0; p1_addr = 10'h055;
    #1;
    chk("t5_gnt1", p1_gnt, 1);
    cyc; p1_req = 0; p0_req = 1; p0_we = 1; p0_addr = 10'h111; p0_wdata = 4'h5; mem_ready = 1; #1;
    chk("t5_wait_b", p0_gnt, 0);
    cyc; mem_ready = 0; p0_addr = 10'h222; #1;
    chk("t5_wait_d", p0_gnt, 0);
    chk("t5_p1done", p1_done, 1);
    cyc; p0_addr = 10'h2AB; #1;
    chk("t5_gnt0", p0_gnt, 1);
    cyc; p0_req = 0; p0_addr = 10'h000; #1;
    chk("t5_addr_b1", mem_addr, 10'h2AB);
    cyc; p0_addr = 10'h3FF; mem_ready = 1; #1;
    chk("t5_addr_b2", mem_addr, 10'h2AB);
    chk("t5_din", mem_data_in, 4'h5);
    cyc; mem_ready = 0; #1;
    chk("t5_done", p0_done, 1);
    cyc;
    // reset in second BUSY cycle drops the op without a done pulse
    p1_req = 1; p1_we = 0; p1_addr = 10'h077;
    #1;
    chk("t6_gnt1", p1_gnt, 1);
    cyc; p1_req = 0; #1;
    cyc; rst_n = 1'b0; #1;
    chk("t6_en", mem_enable, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", p1_done, 0);
    cyc;
    chk("t6_done_after", p1_done, 0);
    #2; rst_n = 1'b1;
    cyc;
    p0_req = 1; p1_req = 1;
    #1;
    chk("t6_tie_gnt0", p0_gnt, 1);
    chk("t6_tie_gnt1", p1_gnt, 0);
    p0_req = 0; p1_req = 0;
    cyc; cyc; cyc;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
